// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector: shift-register window compared against a
// loadable pattern, with a one-cycle match pulse, a saturating match counter and a sticky seen flag.
module seq_detector_param #(
   parameter int unsigned        PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter int unsigned        CNT_W   = 8
) (
   input  logic                             clk_2,
   input  logic                             reset,
   input  logic                             serial_in,
   input  logic                             in_valid,
   input  logic [PAT_LEN-1:0]               pattern_in,
   input  logic                             pattern_load,
   input  logic                             overlap_en,
   input  logic                             count_clr,
   output logic                             match,
   output logic [CNT_W-1:0]                 match_count,
   output logic                             seen,
   output logic [$clog2(PAT_LEN+1)-1:0]     fill
);

   localparam int unsigned        FILL_W  = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0]  FULL    = FILL_W'(PAT_LEN);
   localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

   logic [PAT_LEN-1:0] pat_q;
   logic [PAT_LEN-1:0] win_q;
   logic [PAT_LEN-1:0] win_nxt_c;
   logic [FILL_W-1:0]  fill_inc_c;
   logic               shift_c;
   logic               hit_c;

   // Oldest bit sits in win[0]; a hit needs a full window of fresh bits.
   always_comb begin
      win_nxt_c  = {serial_in, win_q[PAT_LEN-1:1]};
      fill_inc_c = (fill == FULL) ? FULL : fill + FILL_W'(1);
      shift_c    = in_valid && !pattern_load;
      hit_c      = shift_c && (fill_inc_c == FULL) && (win_nxt_c == pat_q);
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         pat_q       <= PATTERN;
         win_q       <= '0;
         fill        <= '0;
         match       <= 1'b0;
         match_count <= '0;
         seen        <= 1'b0;
      end else begin
         if (pattern_load) begin
            pat_q <= pattern_in;
            fill  <= '0;
         end else if (in_valid) begin
            win_q <= win_nxt_c;
            fill  <= (hit_c && !overlap_en) ? FILL_W'(0) : fill_inc_c;
         end

         match <= hit_c;

         // Clear takes effect first so a coincident hit still counts once.
         if (count_clr) begin
            match_count <= hit_c ? CNT_W'(1) : CNT_W'(0);
            seen        <= hit_c;
         end else if (hit_c) begin
            if (match_count != CNT_MAX) begin
               match_count <= match_count + CNT_W'(1);
            end
            seen <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a vector table for the main scenarios plus a
// hand-written sequence for counter saturation on a narrow-counter instance.
module tb_seq_detector_param;

   logic       clk_2 = 1'b0;
   logic       reset;
   logic       serial_in;
   logic       in_valid;
   logic [3:0] pattern_in;
   logic       pattern_load;
   logic       overlap_en;
   logic       count_clr;

   logic       match,  match2;
   logic [7:0] match_count;
   logic [1:0] match_count2;
   logic       seen,   seen2;
   logic [2:0] fill,   fill2;

   int errors = 0;
   int checks = 0;

   always #5 clk_2 = ~clk_2;

   seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
      .clk_2(clk_2), .reset(reset), .serial_in(serial_in), .in_valid(in_valid),
      .pattern_in(pattern_in), .pattern_load(pattern_load), .overlap_en(overlap_en),
      .count_clr(count_clr), .match(match), .match_count(match_count),
      .seen(seen), .fill(fill)
   );

   seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut2 (
      .clk_2(clk_2), .reset(reset), .serial_in(serial_in), .in_valid(in_valid),
      .pattern_in(pattern_in), .pattern_load(pattern_load), .overlap_en(overlap_en),
      .count_clr(count_clr), .match(match2), .match_count(match_count2),
      .seen(seen2), .fill(fill2)
   );

   typedef struct {
      logic       rst;
      logic       sin;
      logic       vld;
      logic [3:0] pin;
      logic       pld;
      logic       ovl;
      logic       clr;
      logic       em;
      logic [7:0] ec;
      logic       es;
      logic [2:0] ef;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic sin, input logic vld, input logic [3:0] pin,
                      input logic pld, input logic ovl, input logic clr,
                      input logic em, input logic [7:0] ec, input logic es, input logic [2:0] ef);
      vec_t v;
      v.rst = rst; v.sin = sin; v.vld = vld; v.pin = pin; v.pld = pld; v.ovl = ovl; v.clr = clr;
      v.em = em; v.ec = ec; v.es = es; v.ef = ef;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample just after the rising edge.
   task automatic drive(input logic rst, input logic sin, input logic vld, input logic [3:0] pin,
                        input logic pld, input logic ovl, input logic clr);
      reset = rst; serial_in = sin; in_valid = vld; pattern_in = pin;
      pattern_load = pld; overlap_en = ovl; count_clr = clr;
      @(posedge clk_2);
      #1;
   endtask

   initial begin
      reset = 1'b1; serial_in = 1'b0; in_valid = 1'b0; pattern_in = 4'h0;
      pattern_load = 1'b0; overlap_en = 1'b1; count_clr = 1'b0;

      //   rst sin vld pin     pld ovl clr | m  cnt s  fill
      // 1: reset, then 1,1,0,1 against reset pattern 1011
      add(1, 0, 0, 4'h0,    0, 1, 0,   0, 0, 0, 0);
      add(0, 1, 1, 4'h0,    0, 1, 0,   0, 0, 0, 1);
      add(0, 1, 1, 4'h0,    0, 1, 0,   0, 0, 0, 2);
      add(0, 0, 1, 4'h0,    0, 1, 0,   0, 0, 0, 3);
      add(0, 1, 1, 4'h0,    0, 1, 0,   1, 1, 1, 4);
      add(0, 1, 0, 4'h0,    0, 1, 0,   0, 1, 1, 4);
      // 2a: load 0101 with clear, overlap on: hits after bits 4 and 6
      add(0, 0, 0, 4'b0101, 1, 1, 1,   0, 0, 0, 0);
      add(0, 1, 1, 4'h0,    0, 1, 0,   0, 0, 0, 1);
      add(0, 0, 1, 4'h0,    0, 1, 0,   0, 0, 0, 2);
      add(0, 1, 1, 4'h0,    0, 1, 0,   0, 0, 0, 3);
      add(0, 0, 1, 4'h0,    0, 1, 0,   1, 1, 1, 4);
      add(0, 1, 1, 4'h0,    0, 1, 0,   0, 1, 1, 4);
      add(0, 0, 1, 4'h0,    0, 1, 0,   1, 2, 1, 4);
      // 2b: same with overlap off: only one hit, fill restarts
      add(0, 0, 0, 4'b0101, 1, 0, 1,   0, 0, 0, 0);
      add(0, 1, 1, 4'h0,    0, 0, 0,   0, 0, 0, 1);
      add(0, 0, 1, 4'h0,    0, 0, 0,   0, 0, 0, 2);
      add(0, 1, 1, 4'h0,    0, 0, 0,   0, 0, 0, 3);
      add(0, 0, 1, 4'h0,    0, 0, 0,   1, 1, 1, 0);
      add(0, 1, 1, 4'h0,    0, 0, 0,   0, 1, 1, 1);
      add(0, 0, 1, 4'h0,    0, 0, 0,   0, 1, 1, 2);
      // 3: pattern 1011, gap of three invalid cycles is ignored
      add(0, 0, 0, 4'b1011, 1, 1, 1,   0, 0, 0, 0);
      add(0, 1, 1, 4'h0,    0, 1, 0,   0, 0, 0, 1);
      add(0, 1, 1, 4'h0,    0, 1, 0,   0, 0, 0, 2);
      add(0, 1, 0, 4'h0,    0, 1, 0,   0, 0, 0, 2);
      add(0, 0, 0, 4'h0,    0, 1, 0,   0, 0, 0, 2);
      add(0, 1, 0, 4'h0,    0, 1, 0,   0, 0, 0, 2);
      add(0, 0, 1, 4'h0,    0, 1, 0,   0, 0, 0, 3);
      add(0, 1, 1, 4'h0,    0, 1, 0,   1, 1, 1, 4);
      // 4: reload at fill=3 with 1111 (serial bit on load cycle ignored); no stale match
      add(0, 0, 0, 4'b1011, 1, 1, 0,   0, 1, 1, 0);
      add(0, 1, 1, 4'h0,    0, 1, 0,   0, 1, 1, 1);
      add(0, 1, 1, 4'h0,    0, 1, 0,   0, 1, 1, 2);
      add(0, 0, 1, 4'h0,    0, 1, 0,   0, 1, 1, 3);
      add(0, 1, 1, 4'b1111, 1, 1, 0,   0, 1, 1, 0);
      add(0, 1, 1, 4'h0,    0, 1, 0,   0, 1, 1, 1);
      add(0, 1, 1, 4'h0,    0, 1, 0,   0, 1, 1, 2);
      add(0, 1, 1, 4'h0,    0, 1, 0,   0, 1, 1, 3);
      add(0, 1, 1, 4'h0,    0, 1, 0,   1, 2, 1, 4);
      add(0, 1, 1, 4'h0,    0, 1, 0,   1, 3, 1, 4);
      // 6: reset at fill=3 discards partial match; final bit alone does not hit
      add(0, 0, 0, 4'b1011, 1, 1, 0,   0, 3, 1, 0);
      add(0, 1, 1, 4'h0,    0, 1, 0,   0, 3, 1, 1);
      add(0, 1, 1, 4'h0,    0, 1, 0,   0, 3, 1, 2);
      add(0, 0, 1, 4'h0,    0, 1, 0,   0, 3, 1, 3);
      add(1, 1, 1, 4'b1111, 1, 1, 0,   0, 0, 0, 0);
      add(0, 1, 1, 4'h0,    0, 1, 0,   0, 0, 0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].sin, vecs[i].vld, vecs[i].pin,
               vecs[i].pld, vecs[i].ovl, vecs[i].clr);
         chk("match", i, 32'(match),       32'(vecs[i].em));
         chk("count", i, 32'(match_count), 32'(vecs[i].ec));
         chk("seen",  i, 32'(seen),        32'(vecs[i].es));
         chk("fill",  i, 32'(fill),        32'(vecs[i].ef));
      end

      // 5: load 1111 with clear, then eight 1s give five overlapping hits
      drive(0, 0, 0, 4'b1111, 1, 1, 1);
      chk("sat_clr_cnt2", 0, 32'(match_count2), 32'd0);
      chk("sat_clr_seen2", 0, 32'(seen2), 32'd0);
      for (int i = 1; i <= 8; i++) begin
         drive(0, 1, 1, 4'h0, 0, 1, 0);
         chk("sat_match2", i, 32'(match2), (i >= 4) ? 32'd1 : 32'd0);
         chk("sat_cnt2", i, 32'(match_count2), (i >= 6) ? 32'd3 : ((i >= 4) ? 32'(i - 3) : 32'd0));
         chk("sat_cnt8", i, 32'(match_count), (i >= 4) ? 32'(i - 3) : 32'd0);
      end
      // idle cycle holds the saturated count and drops match
      drive(0, 1, 0, 4'h0, 0, 1, 0);
      chk("sat_hold_cnt2", 0, 32'(match_count2), 32'd3);
      chk("sat_hold_match2", 0, 32'(match2), 32'd0);
      // clear coincident with a hit: counts restart at one, seen stays set
      drive(0, 1, 1, 4'h0, 0, 1, 1);
      chk("clr_hit_cnt2", 0, 32'(match_count2), 32'd1);
      chk("clr_hit_cnt8", 0, 32'(match_count), 32'd1);
      chk("clr_hit_seen2", 0, 32'(seen2), 32'd1);
      chk("clr_hit_match", 0, 32'(match), 32'd1);
      // clear without a hit empties count and seen
      drive(0, 0, 0, 4'h0, 0, 1, 1);
      chk("clr_only_cnt8", 0, 32'(match_count), 32'd0);
      chk("clr_only_seen", 0, 32'(seen), 32'd0);
      chk("clr_only_fill", 0, 32'(fill), 32'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
